// File: rtl/tx_sched.sv
// Egress transmit scheduler: round-robin, frame-granular sharing of one byte-wide
// MAC transmit interface between NUM_REQ sources, with inter-frame gap and length cap.
module tx_sched #(
   parameter int NUM_REQ    = 4,
   parameter int IFG_CYCLES = 48,
   parameter int MAX_LEN    = 1518
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 mac_valid,
   output logic [7:0]           mac_data,
   output logic                 mac_last,
   input  logic                 mac_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic [15:0]          frames_sent,
   output logic [7:0]           trunc_cnt
);

   localparam int CNT_W = $clog2(MAX_LEN + 1);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int GAP_W = $clog2(IFG_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [15:0]        frames_q, frames_d;
   logic [7:0]         trunc_q, trunc_d;

   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   cand;

   logic               own_valid;
   logic [7:0]         own_data;
   logic               own_last;
   logic               at_max;
   logic               beat_acc;

   // last_ptr holds the current owner for the whole frame, so it doubles as the mux select.
   assign own_valid = req_valid[last_ptr_q];
   assign own_data  = req_data[8*last_ptr_q +: 8];
   assign own_last  = req_last[last_ptr_q];
   assign at_max    = (byte_cnt_q == CNT_W'(MAX_LEN - 1));
   assign beat_acc  = (state_q == S_XFER) && own_valid && mac_ready;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = PTR_W'((int'(last_ptr_q) + i) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      mac_valid = 1'b0;
      mac_data  = 8'h00;
      mac_last  = 1'b0;
      req_ready = '0;
      case (state_q)
         S_XFER: begin
            mac_valid             = own_valid;
            mac_data              = own_data;
            mac_last              = own_last | at_max;
            req_ready[last_ptr_q] = mac_ready;
         end
         S_DRAIN: req_ready[last_ptr_q] = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_ptr_d = last_ptr_q;
      byte_cnt_d = byte_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      frames_d   = frames_q;
      trunc_d    = trunc_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_d    = NUM_REQ'(1) << win_idx;
               last_ptr_d = win_idx;
               byte_cnt_d = '0;
               state_d    = S_XFER;
            end
         end
         S_XFER: begin
            if (beat_acc) begin
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (own_last) begin
                  frames_d  = frames_q + 16'd1;
                  grant_d   = '0;
                  gap_cnt_d = '0;
                  state_d   = S_GAP;
               end else if (at_max) begin
                  // Forced end: the MAC sees a complete frame, the source tail is discarded.
                  frames_d = frames_q + 16'd1;
                  trunc_d  = (trunc_q == 8'hFF) ? trunc_q : trunc_q + 8'd1;
                  state_d  = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (own_valid && own_last) begin
               grant_d   = '0;
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         last_ptr_q <= PTR_W'(NUM_REQ - 1);
         byte_cnt_q <= '0;
         gap_cnt_q  <= '0;
         frames_q   <= '0;
         trunc_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_ptr_q <= last_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         frames_q   <= frames_d;
         trunc_q    <= trunc_d;
      end
   end

   assign grant       = grant_q;
   assign busy        = (state_q != S_IDLE);
   assign frames_sent = frames_q;
   assign trunc_cnt   = trunc_q;

endmodule

// File: doc/tx_sched.md
# tx_sched

Egress transmit scheduler for one switch port. Shares a single byte-wide MAC transmit interface between NUM_REQ frame sources, such as per-ingress-port queues. Each grant covers one whole frame and is issued round-robin. The block enforces an inter-frame gap and truncates over-length frames. It sits between the switch fabric queues and the RMII transmit MAC, which serialises each byte into dibits on `clk`.

## Interface
- NUM_REQ, 4: number of requesters (2–8).
- IFG_CYCLES, 48: idle `clk` cycles between frames (12 byte times × 4 dibits at 50 MHz RMII).
- MAX_LEN, 1518: maximum bytes forwarded per frame.
- CNT_W, derived, $clog2(MAX_LEN+1): width of the byte counter.
- clk  in  1  RMII reference clock; all logic on rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a frame.
- req_ready  out  NUM_REQ  per-requester byte accepted.
- mac_valid  out  1  byte valid to the MAC.
- mac_data  out  8  byte to the MAC.
- mac_last  out  1  final byte of the frame to the MAC.
- mac_ready  in  1  MAC accepts the byte.
- grant  out  NUM_REQ  one-hot current owner; 0 when nobody owns the interface.
- busy  out  1  state is not IDLE.
- frames_sent  out  16  count of frames completed; wraps.
- trunc_cnt  out  8  count of truncated frames; saturates at 255.

## Operation
- State machine IDLE → XFER → (DRAIN) → GAP → IDLE. The registers are state, grant, last_ptr, byte_cnt, gap_cnt, frames_sent and trunc_cnt.
- Reset values:
  - state = IDLE; grant = 0; last_ptr = NUM_REQ-1, so requester 0 wins first.
  - byte_cnt = 0; gap_cnt = 0; frames_sent = 0; trunc_cnt = 0.
  - All outputs are 0.
- IDLE:
  - If any req_valid is high, the winner is the first valid requester searching from last_ptr+1 upward with wrap.
  - On that edge: grant ← onehot(winner), last_ptr ← winner, byte_cnt ← 0, state ← XFER.
  - req_valid is sampled only in IDLE. Requests arriving during XFER, DRAIN or GAP wait.
- XFER, owner g:
  - Combinational pass-through: mac_valid = req_valid[g] and mac_data = req_data[g].
  - req_ready[g] = mac_ready; all other req_ready bits are 0.
  - mac_last = req_last[g] | (byte_cnt == MAX_LEN-1).
  - A beat is accepted when mac_valid & mac_ready; then byte_cnt increments.
  - Accepted beat with req_last[g]: frames_sent increments, grant ← 0, gap_cnt ← 0, state ← GAP.
  - Accepted beat with forced mac_last and no req_last: frames_sent increments, trunc_cnt saturating-increments, state ← DRAIN.
- DRAIN:
  - Outputs: mac_valid = 0, req_ready[g] = 1, grant held.
  - Bytes are discarded until a req_valid & req_last beat, then grant ← 0, gap_cnt ← 0, state ← GAP.
- GAP:
  - All mac_* outputs and all req_ready bits are 0.
  - gap_cnt increments each cycle. When gap_cnt == IFG_CYCLES-1, state ← IDLE.
- busy = (state != IDLE).
- All mac_* outputs and req_ready bits are 0 whenever state is IDLE or GAP.
- Reset asserted mid-operation: all registers return to reset values immediately, asynchronously. mac_valid drops without a mac_last, and the MAC is responsible for discarding the partial frame. last_ptr also resets.
- Requester rule: once it asserts req_valid, a requester holds req_data and req_last stable until req_ready.

## Timing
- Grant latency:
  - req_valid seen high in IDLE at edge t gives grant at t+1.
  - The first byte can be accepted in the same cycle grant rises.
  - Minimum 1 cycle of IDLE per frame.
- Data path latency is 0 cycles, because XFER is combinational pass-through.
- Throughput: 1 byte per cycle when mac_ready is held high. An RMII MAC asserts mac_ready once per 4 cycles.
- Inter-frame timing:
  - Last beat accepted at edge t means mac_valid = 0 for cycles t+1 through t+IFG_CYCLES.
  - IDLE at t+IFG_CYCLES, next grant at t+IFG_CYCLES+1.
- frames_sent and trunc_cnt update on the edge that accepts the counted beat.
- Simultaneous events:
  - Several requesters valid in the same IDLE cycle: only the round-robin winner is granted.
  - Requester 0 valid with last_ptr = 0: requester 0 is granted only if no other requester is valid.

## Test plan
- Reset: drive rst_n low with random inputs → grant=0, req_ready=0, mac_valid=0, busy=0, frames_sent=0, trunc_cnt=0. Deassert rst_n → IDLE.
- Single frame: requester 2 sends 3 bytes 0xA1, 0xB2, 0xC3 with mac_ready=1.
  - grant=4'b0100 one cycle after req_valid.
  - MAC sees A1, B2, C3 with mac_last on C3.
  - mac_valid=0 for the next 48 cycles; frames_sent=1.
- Round-robin: all 4 requesters continuously offer 2-byte frames → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant is separated by 48 gap cycles plus 1 IDLE cycle.
- Backpressure: during a frame, toggle mac_ready 1-0-0-0 (RMII pacing) → req_ready[g] mirrors mac_ready, mac_data is held stable, and exactly one byte transfers per 4 cycles.
- Truncation: MAX_LEN=8; requester 1 sends 12 bytes 0x00–0x0B.
  - MAC receives 0x00–0x07 with mac_last on 0x07.
  - 0x08–0x0B are drained with mac_valid=0.
  - trunc_cnt=1, frames_sent=1, then a 48-cycle gap.
- Reset mid-frame: assert rst_n after 5 bytes of a 10-byte frame → mac_valid and grant go 0 immediately. After release, requester 0 is granted first.
